// File: rtl/pixel_color_pipe.sv
// pixel_color_pipe: 3-stage pixel classifier producing ball/paddle/background RGB
module pixel_color_pipe #(
  parameter int XW = 11,
  parameter int YW = 10,
  parameter int CW = 4,
  parameter int PAD_Y0 = 390,
  parameter int PAD_Y1 = 405,
  parameter int FLASH_FRAMES = 8
) (
  input  logic          iCLK,
  input  logic          iRST_n,
  input  logic          iPIX_VALID,
  input  logic          iFRAME_START,
  input  logic [XW-1:0] iVGA_X,
  input  logic [YW-1:0] iVGA_Y,
  input  logic [XW-1:0] iBALL_X,
  input  logic [YW-1:0] iBALL_Y,
  input  logic [7:0]    iBALL_S,
  input  logic [XW-1:0] iBLOCK_X1,
  input  logic [XW-1:0] iBLOCK_X2,
  input  logic [1:0]    iDISPLAY_MODE,
  input  logic          iHIT,
  output logic [CW-1:0] oVGA_R,
  output logic [CW-1:0] oVGA_G,
  output logic [CW-1:0] oVGA_B,
  output logic          oPIX_VALID
);
  localparam int SQX = 2 * (XW + 1);
  localparam int SQY = 2 * (YW + 1);
  localparam int SW = (SQX > SQY ? SQX : SQY) + 1;
  localparam int CMPW = SW > 16 ? SW : 16;
  localparam logic [YW:0] padTop = (YW + 1)'(PAD_Y0);
  localparam logic [YW:0] padBot = (YW + 1)'(PAD_Y1);
  localparam logic [7:0] flashLoad = 8'(FLASH_FRAMES);
  localparam logic [CW-1:0] full = '1;
  localparam logic [CW-1:0] none = '0;

  logic signed [XW:0] dxNext, s1Dx;
  logic signed [YW:0] dyNext, s1Dy;
  logic [15:0] r2Next, s1R2, s2R2;
  logic padNext, s1Pad, s1Valid, s2Pad, s2Valid;
  logic [XW:0] absDx;
  logic [YW:0] absDy;
  logic [SQX-1:0] dxSqNext, s2DxSq;
  logic [SQY-1:0] dySqNext, s2DySq;
  logic [SW-1:0] distSq;
  logic isBall;
  logic [1:0] mode;
  logic [7:0] flashCnt;
  logic [3*CW-1:0] bgRgb, rgbNext;

  assign dxNext = $signed({1'b0, iVGA_X}) - $signed({1'b0, iBALL_X});
  assign dyNext = $signed({1'b0, iVGA_Y}) - $signed({1'b0, iBALL_Y});
  assign r2Next = {8'd0, iBALL_S} * {8'd0, iBALL_S};
  assign padNext = iBLOCK_X1 <= iVGA_X && iVGA_X <= iBLOCK_X2 &&
                   {1'b0, iVGA_Y} > padTop && {1'b0, iVGA_Y} < padBot;

  // Squaring the magnitude avoids signed-multiply width surprises
  assign absDx = s1Dx[XW] ? $unsigned(-s1Dx) : $unsigned(s1Dx);
  assign absDy = s1Dy[YW] ? $unsigned(-s1Dy) : $unsigned(s1Dy);
  assign dxSqNext = {{(XW + 1){1'b0}}, absDx} * {{(XW + 1){1'b0}}, absDx};
  assign dySqNext = {{(YW + 1){1'b0}}, absDy} * {{(YW + 1){1'b0}}, absDy};

  assign distSq = SW'(s2DxSq) + SW'(s2DySq);
  assign isBall = CMPW'(distSq) <= CMPW'(s2R2);

  // Colour select: ball over paddle over background, blank when not valid
  always_comb begin
    bgRgb = mode == 2'b11 ? {none, full, full} :
            mode == 2'b10 ? {full, none, full} :
            mode == 2'b01 ? {full, full, none} : {full, none, none};
    rgbNext = !s2Valid ? '0 :
              isBall ? {full, full, full} :
              s2Pad ? (flashCnt != 8'd0 ? {full, full, full} : {none, none, full}) : bgRgb;
  end

  // Stage 1: signed offsets from ball centre, radius squared, paddle hit-box
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      s1Dx <= '0;
      s1Dy <= '0;
      s1R2 <= '0;
      s1Pad <= 1'b0;
      s1Valid <= 1'b0;
    end else begin
      s1Dx <= dxNext;
      s1Dy <= dyNext;
      s1R2 <= r2Next;
      s1Pad <= padNext;
      s1Valid <= iPIX_VALID;
    end
  end

  // Stage 2: squared offsets, forward radius, paddle flag and valid
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      s2DxSq <= '0;
      s2DySq <= '0;
      s2R2 <= '0;
      s2Pad <= 1'b0;
      s2Valid <= 1'b0;
    end else begin
      s2DxSq <= dxSqNext;
      s2DySq <= dySqNext;
      s2R2 <= s1R2;
      s2Pad <= s1Pad;
      s2Valid <= s1Valid;
    end
  end

  // Stage 3: registered colour outputs
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      {oVGA_R, oVGA_G, oVGA_B} <= '0;
      oPIX_VALID <= 1'b0;
    end else begin
      {oVGA_R, oVGA_G, oVGA_B} <= rgbNext;
      oPIX_VALID <= s2Valid;
    end
  end

  // Background mode only changes at frame start so a frame never tears
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) mode <= 2'b00;
    else if (iFRAME_START) mode <= iDISPLAY_MODE;
  end

  // Paddle flash: hit reloads, each frame start counts down to zero
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) flashCnt <= '0;
    else if (iHIT) flashCnt <= flashLoad;
    else if (iFRAME_START && flashCnt != 8'd0) flashCnt <= flashCnt - 8'd1;
  end
endmodule

// File: tb/tb_pixel_color_pipe.sv
// tb_pixel_color_pipe: directed vectors checked against a per-cycle behavioural model
module tb_pixel_color_pipe;
  localparam logic [11:0] WHITE = 12'hFFF, BLUE = 12'h00F, RED = 12'hF00;
  localparam logic [11:0] CYAN = 12'h0FF, MAG = 12'hF0F, YEL = 12'hFF0;
  localparam int PY0 = 390, PY1 = 405, FLASH = 2;

  logic iCLK = 1'b0, iRST_n, iPIX_VALID, iFRAME_START, iHIT;
  logic [10:0] iVGA_X, iBALL_X, iBLOCK_X1, iBLOCK_X2;
  logic [9:0] iVGA_Y, iBALL_Y;
  logic [7:0] iBALL_S;
  logic [1:0] iDISPLAY_MODE;
  logic [3:0] oVGA_R, oVGA_G, oVGA_B;
  logic oPIX_VALID;
  int vectors = 0, miscompares = 0;

  typedef struct packed {
    logic v;
    logic [10:0] x, bx, x1, x2;
    logic [9:0] y, by;
    logic [7:0] s;
  } pix_t;

  pix_t h1 = '0, h2 = '0;
  logic [11:0] expRgb = '0;
  logic expV = 1'b0;
  logic [1:0] mMode = 2'b00;
  int mFlash = 0;

  pixel_color_pipe #(.FLASH_FRAMES(FLASH)) dut (
    .iCLK(iCLK), .iRST_n(iRST_n), .iPIX_VALID(iPIX_VALID), .iFRAME_START(iFRAME_START),
    .iVGA_X(iVGA_X), .iVGA_Y(iVGA_Y), .iBALL_X(iBALL_X), .iBALL_Y(iBALL_Y), .iBALL_S(iBALL_S),
    .iBLOCK_X1(iBLOCK_X1), .iBLOCK_X2(iBLOCK_X2), .iDISPLAY_MODE(iDISPLAY_MODE), .iHIT(iHIT),
    .oVGA_R(oVGA_R), .oVGA_G(oVGA_G), .oVGA_B(oVGA_B), .oPIX_VALID(oPIX_VALID)
  );

  always #5 iCLK = ~iCLK;

  function automatic logic [11:0] colour(input pix_t p, input logic [1:0] m, input int fl);
    int dx, dy;
    if (!p.v) return 12'h000;
    dx = int'(p.x) - int'(p.bx);
    dy = int'(p.y) - int'(p.by);
    if (dx * dx + dy * dy <= int'(p.s) * int'(p.s)) return WHITE;
    if (p.x >= p.x1 && p.x <= p.x2 && int'(p.y) > PY0 && int'(p.y) < PY1) return fl != 0 ? WHITE : BLUE;
    return m == 2'b11 ? CYAN : m == 2'b10 ? MAG : m == 2'b01 ? YEL : RED;
  endfunction

  function automatic pix_t curPix();
    return '{v: iPIX_VALID, x: iVGA_X, bx: iBALL_X, x1: iBLOCK_X1, x2: iBLOCK_X2,
             y: iVGA_Y, by: iBALL_Y, s: iBALL_S};
  endfunction

  // Model: a pixel shows two edges after capture, coloured with mode/flash of that moment
  always @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      h1 <= '0;
      h2 <= '0;
      expRgb <= '0;
      expV <= 1'b0;
      mMode <= 2'b00;
      mFlash <= 0;
    end else begin
      expRgb <= colour(h2, mMode, mFlash);
      expV <= h2.v;
      h2 <= h1;
      h1 <= curPix();
      if (iFRAME_START) mMode <= iDISPLAY_MODE;
      if (iHIT) mFlash <= FLASH;
      else if (iFRAME_START && mFlash > 0) mFlash <= mFlash - 1;
    end
  end

  // Every-cycle comparison against the model, away from the active edge
  always @(negedge iCLK) begin
    vectors++;
    if ({oVGA_R, oVGA_G, oVGA_B} !== expRgb || oPIX_VALID !== expV) begin
      miscompares++;
      $display("FAIL cycle t=%0t: got rgb=%h valid=%b, want rgb=%h valid=%b",
               $time, {oVGA_R, oVGA_G, oVGA_B}, oPIX_VALID, expRgb, expV);
    end
  end

  task automatic tick();
    @(posedge iCLK);
    #1;
  endtask

  task automatic checkLit(input string name, input logic [11:0] want, input logic wantV);
    vectors++;
    if ({oVGA_R, oVGA_G, oVGA_B} !== want || oPIX_VALID !== wantV) begin
      miscompares++;
      $display("FAIL %s: got rgb=%h valid=%b, want rgb=%h valid=%b",
               name, {oVGA_R, oVGA_G, oVGA_B}, oPIX_VALID, want, wantV);
    end
  endtask

  task automatic setGeo(input int bx, input int by, input int s, input int x1, input int x2);
    iBALL_X = 11'(bx);
    iBALL_Y = 10'(by);
    iBALL_S = 8'(s);
    iBLOCK_X1 = 11'(x1);
    iBLOCK_X2 = 11'(x2);
  endtask

  task automatic probe(input string name, input int x, input int y, input logic fs,
                       input logic hit, input logic [11:0] want);
    iVGA_X = 11'(x);
    iVGA_Y = 10'(y);
    iPIX_VALID = 1'b1;
    iFRAME_START = fs;
    iHIT = hit;
    tick();
    iPIX_VALID = 1'b0;
    iFRAME_START = 1'b0;
    iHIT = 1'b0;
    tick();
    tick();
    checkLit(name, want, 1'b1);
  endtask

  initial begin
    iRST_n = 1'b0;
    iPIX_VALID = 1'b0;
    iFRAME_START = 1'b0;
    iHIT = 1'b0;
    iDISPLAY_MODE = 2'b00;
    iVGA_X = '0;
    iVGA_Y = '0;
    setGeo(100, 100, 5, 200, 260);
    repeat (3) tick();
    checkLit("reset", 12'h000, 1'b0);
    iRST_n = 1'b1;
    iVGA_X = 11'd100;
    iVGA_Y = 10'd100;
    iPIX_VALID = 1'b1;
    tick();
    checkLit("lat1", 12'h000, 1'b0);
    tick();
    checkLit("lat2", 12'h000, 1'b0);
    tick();
    checkLit("lat3", WHITE, 1'b1);
    iPIX_VALID = 1'b0;
    repeat (3) tick();
    setGeo(10, 10, 20, 200, 260);
    probe("ball_in", 0, 0, 0, 0, WHITE);
    probe("ball_out", 25, 25, 0, 0, RED);
    probe("ball_edge", 30, 10, 0, 0, WHITE);
    setGeo(2, 2, 5, 200, 260);
    probe("ball_wrap", 0, 0, 0, 0, WHITE);
    probe("ball_wrap_out", 8, 2, 0, 0, RED);
    setGeo(50, 50, 0, 200, 260);
    probe("r0_centre", 50, 50, 0, 0, WHITE);
    probe("r0_side", 51, 50, 0, 0, RED);
    setGeo(1000, 50, 3, 200, 260);
    probe("pad_tl", 200, 391, 0, 0, BLUE);
    probe("pad_br", 260, 404, 0, 0, BLUE);
    probe("pad_left", 199, 391, 0, 0, RED);
    probe("pad_top", 200, 390, 0, 0, RED);
    probe("pad_bot", 200, 405, 0, 0, RED);
    setGeo(1000, 50, 3, 300, 250);
    probe("pad_inverted", 280, 395, 0, 0, RED);
    setGeo(1000, 50, 3, 200, 260);
    iDISPLAY_MODE = 2'b11;
    probe("mode_mid", 10, 10, 0, 0, RED);
    probe("mode_frame", 10, 10, 1, 0, CYAN);
    probe("mode_hold", 10, 10, 0, 0, CYAN);
    iDISPLAY_MODE = 2'b10;
    probe("mode_mag", 10, 10, 1, 0, MAG);
    iDISPLAY_MODE = 2'b01;
    probe("mode_yel", 10, 10, 1, 0, YEL);
    iDISPLAY_MODE = 2'b00;
    probe("mode_red", 10, 10, 1, 0, RED);
    probe("flash_hit", 230, 398, 0, 1, WHITE);
    probe("flash_hold", 230, 398, 0, 0, WHITE);
    probe("flash_f1", 230, 398, 1, 0, WHITE);
    probe("flash_f2", 230, 398, 1, 0, BLUE);
    probe("flash_f3", 230, 398, 1, 0, BLUE);
    probe("flash_both", 230, 398, 1, 1, WHITE);
    probe("flash_both_f1", 230, 398, 1, 0, WHITE);
    probe("flash_both_f2", 230, 398, 1, 0, BLUE);
    probe("flash_rehit", 230, 398, 0, 1, WHITE);
    probe("flash_rehit_f1", 230, 398, 1, 0, WHITE);
    probe("flash_reload", 230, 398, 0, 1, WHITE);
    probe("flash_reload_f1", 230, 398, 1, 0, WHITE);
    probe("flash_reload_f2", 230, 398, 1, 0, BLUE);
    setGeo(195, 388, 4, 200, 260);
    iHIT = 1'b1;
    tick();
    iHIT = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (i == 15 || i == 16) checkLit("rst_blank", 12'h000, 1'b0);
      if (i == 17) checkLit("rst_resume", BLUE, 1'b1);
      iVGA_X = 11'(190 + i);
      iVGA_Y = 10'(385 + i);
      iPIX_VALID = 1'b1;
      if (i == 12) begin
        iRST_n = 1'b0;
        #1;
        checkLit("rst_async", 12'h000, 1'b0);
      end
      if (i == 14) iRST_n = 1'b1;
      tick();
    end
    iPIX_VALID = 1'b0;
    repeat (4) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/pixel_color_pipe.md
# pixel_color_pipe

Pipelined, parametrised pixel colour generator for the VGA ball game. Each accepted pixel coordinate is classified as ball, paddle or background, and an RGB colour of configurable depth is produced a fixed 3 cycles later. The background mode is latched only at frame start so a mode change never tears mid-frame. A frame-counted flash timer highlights the paddle after a ball hit. Sits between the VGA timing/coordinate generator and the DAC/output pins, fed by the ball and paddle motion logic.

## Interface
Parameters:
- XW, 11, width of X coordinates (pixel X, ball X, paddle edges)
- YW, 10, width of Y coordinates (pixel Y, ball Y)
- CW, 4, bits per colour channel
- PAD_Y0, 390, paddle top row, exclusive
- PAD_Y1, 405, paddle bottom row, exclusive
- FLASH_FRAMES, 8, frames the paddle flashes after a hit (1..255)

Ports:
- iCLK  in  1  pixel clock; all state on rising edge
- iRST_n  in  1  asynchronous, active-low reset
- iPIX_VALID  in  1  iVGA_X/iVGA_Y valid (active display area)
- iFRAME_START  in  1  one-cycle pulse at the first pixel of each frame
- iVGA_X  in  XW  current pixel X
- iVGA_Y  in  YW  current pixel Y
- iBALL_X  in  XW  ball centre X
- iBALL_Y  in  YW  ball centre Y
- iBALL_S  in  8  ball radius
- iBLOCK_X1  in  XW  paddle left edge, inclusive
- iBLOCK_X2  in  XW  paddle right edge, inclusive
- iDISPLAY_MODE  in  2  requested background mode
- iHIT  in  1  one-cycle pulse: ball struck the paddle
- oVGA_R, oVGA_G, oVGA_B  out  CW each  registered colour channels
- oPIX_VALID  out  1  iPIX_VALID delayed 3 cycles

## Operation
- Stage 1 (registered): dx = iVGA_X − iBALL_X, dy = iVGA_Y − iBALL_Y as signed XW+1 / YW+1 bits; r2 = iBALL_S² (16 bits); paddle flag = (iBLOCK_X1 ≤ iVGA_X ≤ iBLOCK_X2) && (PAD_Y0 < iVGA_Y < PAD_Y1); valid bit.
- Stage 2 (registered): dx², dy² unsigned, 2·(XW+1) and 2·(YW+1) bits; r2, paddle flag and valid forwarded.
- Stage 3 (output register): ball = (dx² + dy²) ≤ r2, sum one bit wider than the larger square, no truncation. Priority: ball > paddle > background.
- Colours (F = all-ones of CW, 0 = zero): ball {F,F,F}; paddle {0,0,F}, or {F,F,F} while flash counter ≠ 0; background per latched mode: 11 {0,F,F}, 10 {F,0,F}, 01 {F,F,0}, 00 {F,0,0}.
- Stage-3 valid low → outputs {0,0,0} (blanking).
- Mode register: loads iDISPLAY_MODE only on a cycle with iFRAME_START=1; holds otherwise. New mode applies from the first pixel of that frame, since pixels carry the mode value current when they reach stage 3.
- Flash counter (8 bits): iHIT loads FLASH_FRAMES. Otherwise iFRAME_START decrements when nonzero. Saturates at 0. Both pulses in one cycle → load wins, no decrement that cycle. Repeated iHIT reloads.
- Mode and flash values are sampled at stage 3, not at stage 1.

## Timing
- Latency: pixel presented at cycle n appears on outputs at the clock edge ending cycle n+2, valid during cycle n+3. Throughput 1 pixel/cycle; no stall or back-pressure.
- oPIX_VALID is exactly iPIX_VALID delayed 3 cycles.
- Reset (asynchronous assert, synchronous-to-clock deassert handled upstream): oVGA_R/G/B = 0, oPIX_VALID = 0, all pipeline valid bits 0, mode register = 00 (red), flash counter = 0.
- Reset mid-frame: pipeline flushed; first 3 cycles after release output blanking regardless of inputs.
- Ball radius 0: only the centre pixel is ball (dx = dy = 0 ≤ 0).
- Ball partially off-screen (dx or dy negative or wrapped): signed subtraction keeps the distance correct; no wrap artefacts.
- iBLOCK_X1 > iBLOCK_X2: paddle never drawn.

## Test plan
- Reset, then iPIX_VALID=1, X=100,Y=100, ball (100,100,S=5) → 3 cycles later RGB = {F,F,F}, oPIX_VALID=1; before that all zeros.
- Ball (10,10,S=20), pixel (0,0) → ball (200 ≤ 400); pixel (25,25) with same ball → background red {F,0,0}; pixel (30,10) → ball (boundary 400 ≤ 400).
- Paddle X1=200,X2=260: pixels (200,391), (260,404) → {0,0,F}; (199,391), (200,390), (200,405) → background.
- iDISPLAY_MODE=11 driven mid-frame → background stays red until next iFRAME_START, then {0,F,F} from the first pixel of that frame.
- FLASH_FRAMES=2: iHIT pulse → paddle white for that frame and the next, blue after the 2nd iFRAME_START; iHIT coincident with iFRAME_START → counter = 2, not 1.
- Stream continuous pixels, assert iRST_n=0 mid-stream → outputs 0 immediately, oPIX_VALID low for 3 cycles after release, then correct colours resume.
